// File: rtl/nac_axi_arbiter.sv
// N-to-1 AXI4 arbiter: independent write and read ownership over one slave port.
// Fixed-priority or round-robin selection, optional lock to a single master.
module nac_axi_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 lock_en,
    input  logic [$clog2(NUM_MASTERS)-1:0]       lock_id,

    input  logic [NUM_MASTERS*ADDR_W-1:0]        s_awaddr,
    input  logic [NUM_MASTERS*8-1:0]             s_awlen,
    input  logic [NUM_MASTERS*3-1:0]             s_awsize,
    input  logic [NUM_MASTERS*2-1:0]             s_awburst,
    input  logic [NUM_MASTERS-1:0]               s_awvalid,
    output logic [NUM_MASTERS-1:0]               s_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]        s_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]    s_wstrb,
    input  logic [NUM_MASTERS-1:0]               s_wlast,
    input  logic [NUM_MASTERS-1:0]               s_wvalid,
    output logic [NUM_MASTERS-1:0]               s_wready,
    output logic [NUM_MASTERS-1:0]               s_bvalid,
    output logic [NUM_MASTERS*2-1:0]             s_bresp,
    input  logic [NUM_MASTERS-1:0]               s_bready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]        s_araddr,
    input  logic [NUM_MASTERS*8-1:0]             s_arlen,
    input  logic [NUM_MASTERS*3-1:0]             s_arsize,
    input  logic [NUM_MASTERS*2-1:0]             s_arburst,
    input  logic [NUM_MASTERS-1:0]               s_arvalid,
    output logic [NUM_MASTERS-1:0]               s_arready,
    output logic [NUM_MASTERS-1:0]               s_rvalid,
    output logic [NUM_MASTERS*DATA_W-1:0]        s_rdata,
    output logic [NUM_MASTERS*2-1:0]             s_rresp,
    output logic [NUM_MASTERS-1:0]               s_rlast,
    input  logic [NUM_MASTERS-1:0]               s_rready,

    output logic [ADDR_W-1:0]                    m_awaddr,
    output logic [7:0]                           m_awlen,
    output logic [2:0]                           m_awsize,
    output logic [1:0]                           m_awburst,
    output logic                                 m_awvalid,
    input  logic                                 m_awready,
    output logic [DATA_W-1:0]                    m_wdata,
    output logic [DATA_W/8-1:0]                  m_wstrb,
    output logic                                 m_wlast,
    output logic                                 m_wvalid,
    input  logic                                 m_wready,
    input  logic                                 m_bvalid,
    input  logic [1:0]                           m_bresp,
    output logic                                 m_bready,
    output logic [ADDR_W-1:0]                    m_araddr,
    output logic [7:0]                           m_arlen,
    output logic [2:0]                           m_arsize,
    output logic [1:0]                           m_arburst,
    output logic                                 m_arvalid,
    input  logic                                 m_arready,
    input  logic                                 m_rvalid,
    input  logic [DATA_W-1:0]                    m_rdata,
    input  logic [1:0]                           m_rresp,
    input  logic                                 m_rlast,
    output logic                                 m_rready,

    output logic [NUM_MASTERS-1:0]               wr_grant,
    output logic [NUM_MASTERS-1:0]               rd_grant,
    output logic                                 err_wlast
);

    localparam int N      = NUM_MASTERS;
    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rd_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [N-1:0]     wr_grant_q, wr_grant_d;
    logic [N-1:0]     rd_grant_q, rd_grant_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             err_wlast_q, err_wlast_d;

    logic [N-1:0]     elig_mask;
    logic [N-1:0]     aw_req;
    logic [N-1:0]     ar_req;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_last_hs;

    // Fixed mode: lowest index wins. Round-robin: first requester after ptr.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N-1:0]     req,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] win;
        int               j;
        win = '0;
        if (ARB_MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) win = IDX_W'(i);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = (int'(ptr) + 1 + k) % N;
                if (req[j]) win = IDX_W'(j);
            end
        end
        return win;
    endfunction

    assign elig_mask = lock_en ? (N'(1) << lock_id) : {N{1'b1}};
    assign aw_req    = s_awvalid & elig_mask;
    assign ar_req    = s_arvalid & elig_mask;

    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign b_hs      = m_bvalid & m_bready;
    assign ar_hs     = m_arvalid & m_arready;
    assign r_last_hs = m_rvalid & m_rready & m_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= W_IDLE;
            rd_state_q  <= R_IDLE;
            wr_grant_q  <= '0;
            rd_grant_q  <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            wr_ptr_q    <= IDX_W'(N - 1);
            rd_ptr_q    <= IDX_W'(N - 1);
            beat_cnt_q  <= '0;
            err_wlast_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_grant_q  <= wr_grant_d;
            rd_grant_q  <= rd_grant_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            err_wlast_q <= err_wlast_d;
        end
    end

    // NOTE: every variable gets its hold value before the case so no path infers a latch.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_grant_d  = wr_grant_q;
        wr_idx_d    = wr_idx_q;
        wr_ptr_d    = wr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        err_wlast_d = err_wlast_q;
        case (wr_state_q)
            W_IDLE: begin
                if (|aw_req) begin
                    wr_idx_d   = pick_winner(aw_req, wr_ptr_q);
                    wr_grant_d = N'(1) << wr_idx_d;
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) begin
                    beat_cnt_d = m_awlen;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Mismatch is only flagged; the burst still ends on the master's wlast.
                    if (m_wlast != (beat_cnt_q == 8'd0)) err_wlast_d = 1'b1;
                    if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
                    if (m_wlast) wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_grant_d = '0;
                    wr_ptr_d   = wr_idx_q;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (|ar_req) begin
                    rd_idx_d   = pick_winner(ar_req, rd_ptr_q);
                    rd_grant_d = N'(1) << rd_idx_d;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_last_hs) begin
                    rd_grant_d = '0;
                    rd_ptr_d   = rd_idx_q;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // NOTE: handshake outputs are forced low while rst is high so nothing completes
    // on the reset edge, even though the state registers still hold the old phase.
    always_comb begin
        m_awaddr  = s_awaddr[int'(wr_idx_q)*ADDR_W +: ADDR_W];
        m_awlen   = s_awlen[int'(wr_idx_q)*8 +: 8];
        m_awsize  = s_awsize[int'(wr_idx_q)*3 +: 3];
        m_awburst = s_awburst[int'(wr_idx_q)*2 +: 2];
        m_wdata   = s_wdata[int'(wr_idx_q)*DATA_W +: DATA_W];
        m_wstrb   = s_wstrb[int'(wr_idx_q)*STRB_W +: STRB_W];
        m_wlast   = s_wlast[wr_idx_q];
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_grant_q[i]) s_bresp[i*2 +: 2] = m_bresp;
        end
        if (!rst) begin
            case (wr_state_q)
                W_ADDR: begin
                    m_awvalid = s_awvalid[wr_idx_q];
                    s_awready = wr_grant_q & {N{m_awready}};
                end
                W_DATA: begin
                    m_wvalid = s_wvalid[wr_idx_q];
                    s_wready = wr_grant_q & {N{m_wready}};
                end
                W_RESP: begin
                    m_bready = s_bready[wr_idx_q];
                    s_bvalid = wr_grant_q & {N{m_bvalid}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_araddr  = s_araddr[int'(rd_idx_q)*ADDR_W +: ADDR_W];
        m_arlen   = s_arlen[int'(rd_idx_q)*8 +: 8];
        m_arsize  = s_arsize[int'(rd_idx_q)*3 +: 3];
        m_arburst = s_arburst[int'(rd_idx_q)*2 +: 2];
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        if (!rst) begin
            case (rd_state_q)
                R_ADDR: begin
                    m_arvalid = s_arvalid[rd_idx_q];
                    s_arready = rd_grant_q & {N{m_arready}};
                end
                R_DATA: begin
                    m_rready = s_rready[rd_idx_q];
                    s_rvalid = rd_grant_q & {N{m_rvalid}};
                end
                default: ;
            endcase
        end
    end

    // Read payload goes to everyone; only the owner sees rvalid.
    assign s_rdata   = {N{m_rdata}};
    assign s_rresp   = {N{m_rresp}};
    assign s_rlast   = {N{m_rlast}};

    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;
    assign err_wlast = err_wlast_q;

endmodule

// File: tb/tb_nac_axi_arbiter.sv
// Directed bench: a 2-master fixed-priority instance and a 4-master round-robin instance.
module tb_nac_axi_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // ---------------- fixed-priority instance, 2 masters ----------------
    logic        f_lock_en;
    logic [0:0]  f_lock_id;
    logic [63:0] f_awaddr, f_wdata, f_araddr, f_rdata;
    logic [15:0] f_awlen, f_arlen;
    logic [5:0]  f_awsize, f_arsize;
    logic [3:0]  f_awburst, f_arburst, f_bresp, f_rresp;
    logic [7:0]  f_wstrb;
    logic [1:0]  f_awvalid, f_awready, f_wlast, f_wvalid, f_wready, f_bvalid, f_bready;
    logic [1:0]  f_arvalid, f_arready, f_rvalid, f_rlast, f_rready;
    logic [1:0]  f_wr_grant, f_rd_grant;
    logic        f_err;
    logic [31:0] fm_awaddr, fm_wdata, fm_araddr, fm_rdata;
    logic [7:0]  fm_awlen, fm_arlen;
    logic [2:0]  fm_awsize, fm_arsize;
    logic [1:0]  fm_awburst, fm_arburst, fm_bresp, fm_rresp;
    logic [3:0]  fm_wstrb;
    logic        fm_awvalid, fm_awready, fm_wlast, fm_wvalid, fm_wready, fm_bvalid, fm_bready;
    logic        fm_arvalid, fm_arready, fm_rvalid, fm_rlast, fm_rready;

    // ---------------- round-robin instance, 4 masters ----------------
    logic         r_lock_en;
    logic [1:0]   r_lock_id;
    logic [127:0] r_awaddr, r_wdata, r_araddr, r_rdata;
    logic [31:0]  r_awlen, r_arlen;
    logic [11:0]  r_awsize, r_arsize;
    logic [7:0]   r_awburst, r_arburst, r_bresp, r_rresp;
    logic [15:0]  r_wstrb;
    logic [3:0]   r_awvalid, r_awready, r_wlast, r_wvalid, r_wready, r_bvalid, r_bready;
    logic [3:0]   r_arvalid, r_arready, r_rvalid, r_rlast, r_rready;
    logic [3:0]   r_wr_grant, r_rd_grant;
    logic         r_err;
    logic [31:0]  rm_awaddr, rm_wdata, rm_araddr, rm_rdata;
    logic [7:0]   rm_awlen, rm_arlen;
    logic [2:0]   rm_awsize, rm_arsize;
    logic [1:0]   rm_awburst, rm_arburst, rm_bresp, rm_rresp;
    logic [3:0]   rm_wstrb;
    logic         rm_awvalid, rm_awready, rm_wlast, rm_wvalid, rm_wready, rm_bvalid, rm_bready;
    logic         rm_arvalid, rm_arready, rm_rvalid, rm_rlast, rm_rready;

    nac_axi_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .lock_en(f_lock_en), .lock_id(f_lock_id),
        .s_awaddr(f_awaddr), .s_awlen(f_awlen), .s_awsize(f_awsize), .s_awburst(f_awburst),
        .s_awvalid(f_awvalid), .s_awready(f_awready),
        .s_wdata(f_wdata), .s_wstrb(f_wstrb), .s_wlast(f_wlast), .s_wvalid(f_wvalid), .s_wready(f_wready),
        .s_bvalid(f_bvalid), .s_bresp(f_bresp), .s_bready(f_bready),
        .s_araddr(f_araddr), .s_arlen(f_arlen), .s_arsize(f_arsize), .s_arburst(f_arburst),
        .s_arvalid(f_arvalid), .s_arready(f_arready),
        .s_rvalid(f_rvalid), .s_rdata(f_rdata), .s_rresp(f_rresp), .s_rlast(f_rlast), .s_rready(f_rready),
        .m_awaddr(fm_awaddr), .m_awlen(fm_awlen), .m_awsize(fm_awsize), .m_awburst(fm_awburst),
        .m_awvalid(fm_awvalid), .m_awready(fm_awready),
        .m_wdata(fm_wdata), .m_wstrb(fm_wstrb), .m_wlast(fm_wlast), .m_wvalid(fm_wvalid), .m_wready(fm_wready),
        .m_bvalid(fm_bvalid), .m_bresp(fm_bresp), .m_bready(fm_bready),
        .m_araddr(fm_araddr), .m_arlen(fm_arlen), .m_arsize(fm_arsize), .m_arburst(fm_arburst),
        .m_arvalid(fm_arvalid), .m_arready(fm_arready),
        .m_rvalid(fm_rvalid), .m_rdata(fm_rdata), .m_rresp(fm_rresp), .m_rlast(fm_rlast), .m_rready(fm_rready),
        .wr_grant(f_wr_grant), .rd_grant(f_rd_grant), .err_wlast(f_err)
    );

    nac_axi_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .lock_en(r_lock_en), .lock_id(r_lock_id),
        .s_awaddr(r_awaddr), .s_awlen(r_awlen), .s_awsize(r_awsize), .s_awburst(r_awburst),
        .s_awvalid(r_awvalid), .s_awready(r_awready),
        .s_wdata(r_wdata), .s_wstrb(r_wstrb), .s_wlast(r_wlast), .s_wvalid(r_wvalid), .s_wready(r_wready),
        .s_bvalid(r_bvalid), .s_bresp(r_bresp), .s_bready(r_bready),
        .s_araddr(r_araddr), .s_arlen(r_arlen), .s_arsize(r_arsize), .s_arburst(r_arburst),
        .s_arvalid(r_arvalid), .s_arready(r_arready),
        .s_rvalid(r_rvalid), .s_rdata(r_rdata), .s_rresp(r_rresp), .s_rlast(r_rlast), .s_rready(r_rready),
        .m_awaddr(rm_awaddr), .m_awlen(rm_awlen), .m_awsize(rm_awsize), .m_awburst(rm_awburst),
        .m_awvalid(rm_awvalid), .m_awready(rm_awready),
        .m_wdata(rm_wdata), .m_wstrb(rm_wstrb), .m_wlast(rm_wlast), .m_wvalid(rm_wvalid), .m_wready(rm_wready),
        .m_bvalid(rm_bvalid), .m_bresp(rm_bresp), .m_bready(rm_bready),
        .m_araddr(rm_araddr), .m_arlen(rm_arlen), .m_arsize(rm_arsize), .m_arburst(rm_arburst),
        .m_arvalid(rm_arvalid), .m_arready(rm_arready),
        .m_rvalid(rm_rvalid), .m_rdata(rm_rdata), .m_rresp(rm_rresp), .m_rlast(rm_rlast), .m_rready(rm_rready),
        .wr_grant(r_wr_grant), .rd_grant(r_rd_grant), .err_wlast(r_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Returns 1 ns after the rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Precondition: write FSM just entered W_ADDR for master m with awlen=0 and awvalid held.
    task automatic fx_write_rest(input int m);
        tick();
        f_awvalid[m] = 1'b0;
        f_wvalid[m]  = 1'b1;
        f_wlast[m]   = 1'b1;
        tick();
        f_wvalid     = '0;
        f_wlast      = '0;
        f_bready[m]  = 1'b1;
        fm_bvalid    = 1'b1;
        tick();
        fm_bvalid    = 1'b0;
        f_bready     = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        f_awvalid = 2'b01;
        r_arvalid = 4'hF;
        tick();
        tick();
        settle();
        checks++; if (f_wr_grant !== 2'b00) begin failures++; $display("FAIL rst_wr_grant: got %b want 00", f_wr_grant); end
        checks++; if (f_rd_grant !== 2'b00) begin failures++; $display("FAIL rst_rd_grant: got %b want 00", f_rd_grant); end
        checks++; if (f_err !== 1'b0) begin failures++; $display("FAIL rst_err_wlast: got %b want 0", f_err); end
        checks++; if (fm_awvalid !== 1'b0 || f_awready !== 2'b00) begin failures++; $display("FAIL rst_aw_handshake: got awvalid=%b awready=%b want 0/00", fm_awvalid, f_awready); end
        checks++; if (r_rd_grant !== 4'b0000) begin failures++; $display("FAIL rst_rr_rd_grant: got %b want 0000", r_rd_grant); end
        f_awvalid = '0;
        r_arvalid = '0;
        rst       = 1'b0;
        tick();
        checks++; if (f_wr_grant !== 2'b00) begin failures++; $display("FAIL rst_idle_no_req: got %b want 00", f_wr_grant); end
    endtask

    task automatic test_fixed_priority();
        f_awaddr  = {32'h0000_2000, 32'h0000_1000};
        f_awlen   = '0;
        f_wdata   = {32'hBBBB_0001, 32'hAAAA_0001};
        f_wstrb   = 8'hFF;
        f_awvalid = 2'b11;
        settle();
        checks++; if (f_wr_grant !== 2'b00 || fm_awvalid !== 1'b0) begin failures++; $display("FAIL fp_latency: got grant=%b awvalid=%b want 00/0", f_wr_grant, fm_awvalid); end
        tick();
        checks++; if (f_wr_grant !== 2'b01) begin failures++; $display("FAIL fp_grant_m0: got %b want 01", f_wr_grant); end
        checks++; if (fm_awaddr !== 32'h0000_1000 || fm_awvalid !== 1'b1) begin failures++; $display("FAIL fp_aw_forward: got addr=%h valid=%b want 00001000/1", fm_awaddr, fm_awvalid); end
        checks++; if (f_awready !== 2'b01) begin failures++; $display("FAIL fp_awready_owner: got %b want 01", f_awready); end
        tick();
        f_awvalid = 2'b10;
        f_wvalid  = 2'b01;
        f_wlast   = 2'b01;
        settle();
        checks++; if (fm_wdata !== 32'hAAAA_0001 || fm_wvalid !== 1'b1 || fm_wlast !== 1'b1) begin failures++; $display("FAIL fp_w_forward: got data=%h valid=%b last=%b want aaaa0001/1/1", fm_wdata, fm_wvalid, fm_wlast); end
        checks++; if (f_wready !== 2'b01) begin failures++; $display("FAIL fp_wready_owner: got %b want 01", f_wready); end
        tick();
        f_wvalid  = '0;
        f_wlast   = '0;
        f_bready  = 2'b11;
        fm_bvalid = 1'b1;
        fm_bresp  = 2'b01;
        settle();
        checks++; if (f_bvalid !== 2'b01) begin failures++; $display("FAIL fp_bvalid_owner: got %b want 01", f_bvalid); end
        checks++; if (f_bresp !== 4'b0001) begin failures++; $display("FAIL fp_bresp_route: got %b want 0001", f_bresp); end
        checks++; if (f_wr_grant !== 2'b01) begin failures++; $display("FAIL fp_hold_until_b: got %b want 01", f_wr_grant); end
        tick();
        fm_bvalid = 1'b0;
        fm_bresp  = 2'b00;
        f_bready  = '0;
        checks++; if (f_wr_grant !== 2'b00) begin failures++; $display("FAIL fp_release: got %b want 00", f_wr_grant); end
        tick();
        checks++; if (f_wr_grant !== 2'b10) begin failures++; $display("FAIL fp_grant_m1: got %b want 10", f_wr_grant); end
        fx_write_rest(1);
        checks++; if (f_wr_grant !== 2'b00 || f_err !== 1'b0) begin failures++; $display("FAIL fp_done: got grant=%b err=%b want 00/0", f_wr_grant, f_err); end
    endtask

    task automatic test_lock();
        f_lock_en = 1'b1;
        f_lock_id = 1'b1;
        f_awlen   = '0;
        f_awvalid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (f_wr_grant !== 2'b00) begin failures++; $display("FAIL lock_block cycle %0d: got %b want 00", i, f_wr_grant); end
        end
        f_lock_en = 1'b0;
        tick();
        checks++; if (f_wr_grant !== 2'b01) begin failures++; $display("FAIL lock_release_grant: got %b want 01", f_wr_grant); end
        fx_write_rest(0);
        f_lock_id = 1'b0;
    endtask

    task automatic test_wlast_error();
        f_awlen   = {8'd0, 8'd3};
        f_awvalid = 2'b01;
        tick();
        checks++; if (f_wr_grant !== 2'b01) begin failures++; $display("FAIL wl_grant: got %b want 01", f_wr_grant); end
        tick();
        f_awvalid = '0;
        f_wvalid  = 2'b01;
        f_wlast   = 2'b00;
        tick();
        tick();
        f_wlast   = 2'b01;
        settle();
        checks++; if (f_err !== 1'b0) begin failures++; $display("FAIL wl_no_early_err: got %b want 0", f_err); end
        tick();
        settle();
        checks++; if (f_err !== 1'b1) begin failures++; $display("FAIL wl_err_set: got %b want 1", f_err); end
        checks++; if (fm_wvalid !== 1'b0) begin failures++; $display("FAIL wl_wvalid_in_resp: got %b want 0", fm_wvalid); end
        f_wvalid  = '0;
        f_wlast   = '0;
        f_bready  = 2'b01;
        fm_bvalid = 1'b1;
        settle();
        checks++; if (f_bvalid !== 2'b01) begin failures++; $display("FAIL wl_reach_resp: got %b want 01", f_bvalid); end
        tick();
        fm_bvalid = 1'b0;
        f_bready  = '0;
        checks++; if (f_wr_grant !== 2'b00 || f_err !== 1'b1) begin failures++; $display("FAIL wl_idle_sticky: got grant=%b err=%b want 00/1", f_wr_grant, f_err); end
    endtask

    task automatic test_concurrent();
        f_awlen   = '0;
        f_arlen   = '0;
        f_araddr  = {32'h0000_B000, 32'h0000_A000};
        f_awvalid = 2'b01;
        f_arvalid = 2'b10;
        tick();
        checks++; if (f_wr_grant !== 2'b01 || f_rd_grant !== 2'b10) begin failures++; $display("FAIL cc_grants: got wr=%b rd=%b want 01/10", f_wr_grant, f_rd_grant); end
        checks++; if (f_awready !== 2'b01 || f_arready !== 2'b10) begin failures++; $display("FAIL cc_addr_ready: got aw=%b ar=%b want 01/10", f_awready, f_arready); end
        checks++; if (fm_araddr !== 32'h0000_B000 || fm_awaddr !== 32'h0000_1000) begin failures++; $display("FAIL cc_addr_route: got ar=%h aw=%h want 0000b000/00001000", fm_araddr, fm_awaddr); end
        tick();
        f_awvalid = '0;
        f_arvalid = '0;
        f_wvalid  = 2'b01;
        f_wlast   = 2'b01;
        f_rready  = 2'b10;
        fm_rvalid = 1'b1;
        fm_rlast  = 1'b1;
        fm_rdata  = 32'hCAFE_F00D;
        settle();
        checks++; if (f_rvalid !== 2'b10 || fm_rready !== 1'b1) begin failures++; $display("FAIL cc_r_route: got rvalid=%b m_rready=%b want 10/1", f_rvalid, fm_rready); end
        checks++; if (f_rdata[63:32] !== 32'hCAFE_F00D) begin failures++; $display("FAIL cc_rdata: got %h want cafef00d", f_rdata[63:32]); end
        checks++; if (f_wready !== 2'b01 || fm_wvalid !== 1'b1) begin failures++; $display("FAIL cc_w_route: got wready=%b m_wvalid=%b want 01/1", f_wready, fm_wvalid); end
        tick();
        f_wvalid  = '0;
        f_wlast   = '0;
        f_rready  = '0;
        fm_rvalid = 1'b0;
        fm_rlast  = 1'b0;
        fm_bvalid = 1'b1;
        f_bready  = 2'b10;
        settle();
        checks++; if (f_rd_grant !== 2'b00 || f_wr_grant !== 2'b01) begin failures++; $display("FAIL cc_rd_release: got rd=%b wr=%b want 00/01", f_rd_grant, f_wr_grant); end
        checks++; if (fm_bready !== 1'b0 || f_bvalid !== 2'b01) begin failures++; $display("FAIL cc_b_nonowner: got m_bready=%b bvalid=%b want 0/01", fm_bready, f_bvalid); end
        f_bready  = 2'b01;
        settle();
        checks++; if (fm_bready !== 1'b1) begin failures++; $display("FAIL cc_b_owner: got %b want 1", fm_bready); end
        tick();
        fm_bvalid = 1'b0;
        f_bready  = '0;
        checks++; if (f_wr_grant !== 2'b00) begin failures++; $display("FAIL cc_wr_release: got %b want 00", f_wr_grant); end
    endtask

    task automatic test_rr_reads();
        logic [3:0] exp_seq [5];
        logic [3:0] seen    [5];
        logic [3:0] prev;
        int         n;
        exp_seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seen       = '{default: 4'b0000};
        prev       = 4'b0000;
        n          = 0;
        r_arlen    = '0;
        r_arvalid  = 4'hF;
        r_rready   = 4'hF;
        rm_arready = 1'b1;
        rm_rvalid  = 1'b1;
        rm_rlast   = 1'b1;
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            if (r_rd_grant != 4'b0000 && r_rd_grant != prev) begin
                seen[n] = r_rd_grant;
                n++;
            end
            prev = r_rd_grant;
        end
        checks++; if (n != 5) begin failures++; $display("FAIL rr_budget: got %0d grants want 5", n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (seen[k] !== exp_seq[k]) begin failures++; $display("FAIL rr_seq[%0d]: got %b want %b", k, seen[k], exp_seq[k]); end
        end
        for (int c = 0; c < 10 && r_rd_grant != 4'b0000; c++) tick();
        r_arvalid = '0;
        r_rready  = '0;
        rm_rvalid = 1'b0;
        rm_rlast  = 1'b0;
        tick();
        checks++; if (r_rd_grant !== 4'b0000) begin failures++; $display("FAIL rr_drain: got %b want 0000", r_rd_grant); end
    endtask

    task automatic test_reset_mid_burst();
        f_awlen   = {8'd0, 8'd3};
        f_awvalid = 2'b01;
        tick();
        tick();
        f_awvalid = '0;
        f_wvalid  = 2'b01;
        f_wlast   = '0;
        tick();
        tick();
        rst = 1'b1;
        settle();
        checks++; if (fm_wvalid !== 1'b0 || f_wready !== 2'b00) begin failures++; $display("FAIL mr_gate_in_rst: got m_wvalid=%b wready=%b want 0/00", fm_wvalid, f_wready); end
        tick();
        checks++; if (f_wr_grant !== 2'b00 || f_err !== 1'b0 || fm_wvalid !== 1'b0) begin failures++; $display("FAIL mr_after_rst: got grant=%b err=%b m_wvalid=%b want 00/0/0", f_wr_grant, f_err, fm_wvalid); end
        rst      = 1'b0;
        f_wvalid = '0;
        tick();
        checks++; if (f_wr_grant !== 2'b00 || fm_awvalid !== 1'b0) begin failures++; $display("FAIL mr_idle: got grant=%b m_awvalid=%b want 00/0", f_wr_grant, fm_awvalid); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        f_lock_en = 1'b0; f_lock_id = '0;
        f_awaddr  = '0; f_awlen = '0; f_awsize = '0; f_awburst = '0; f_awvalid = '0;
        f_wdata   = '0; f_wstrb = '0; f_wlast = '0; f_wvalid = '0; f_bready = '0;
        f_araddr  = '0; f_arlen = '0; f_arsize = '0; f_arburst = '0; f_arvalid = '0; f_rready = '0;
        fm_awready = 1'b1; fm_wready = 1'b1; fm_arready = 1'b1;
        fm_bvalid = 1'b0; fm_bresp = '0; fm_rvalid = 1'b0; fm_rdata = '0; fm_rresp = '0; fm_rlast = 1'b0;
        r_lock_en = 1'b0; r_lock_id = '0;
        r_awaddr  = '0; r_awlen = '0; r_awsize = '0; r_awburst = '0; r_awvalid = '0;
        r_wdata   = '0; r_wstrb = '0; r_wlast = '0; r_wvalid = '0; r_bready = '0;
        r_araddr  = '0; r_arlen = '0; r_arsize = '0; r_arburst = '0; r_arvalid = '0; r_rready = '0;
        rm_awready = 1'b1; rm_wready = 1'b1; rm_arready = 1'b1;
        rm_bvalid = 1'b0; rm_bresp = '0; rm_rvalid = 1'b0; rm_rdata = '0; rm_rresp = '0; rm_rlast = 1'b0;

        test_reset();
        test_fixed_priority();
        test_lock();
        test_wlast_error();
        test_concurrent();
        test_rr_reads();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
